// File: rtl/ysyx_24100005_lsu.sv
// ysyx_24100005_lsu: multi-cycle load/store unit.
// Accepts one EXU request at a time. It issues an aligned bus transaction to a
// variable-latency memory slave and returns a single-cycle completion pulse.
// Load data is lane-extracted and extended. Store data is lane-shifted and gets
// a byte write-mask. Misaligned accesses and illegal funct3 values complete with
// an error and never reach the bus.
module ysyx_24100005_lsu #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int   OFF_W = $clog2(MASK_W);
    localparam logic IS64  = (DATA_W == 64);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // funct3 legality; 64-bit accesses (ld/lwu/sd) only exist on a 64-bit bus
    function automatic logic op_legal(input logic wen, input logic [2:0] f3);
        logic ok;
        if (wen) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                3'b011:                 ok = IS64;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                3'b011, 3'b110:                         ok = IS64;
                default:                                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // the offset must be a multiple of the access size (1/2/4/8 bytes)
    function automatic logic misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [2:0] am;
        case (sz)
            2'b00:   am = 3'b000;
            2'b01:   am = 3'b001;
            2'b10:   am = 3'b011;
            default: am = 3'b111;
        endcase
        return |(off & OFF_W'(am));
    endfunction

    // byte enables for a store of the given size starting at lane off
    function automatic logic [MASK_W-1:0] store_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [7:0] bm;
        case (sz)
            2'b00:   bm = 8'h01;
            2'b01:   bm = 8'h03;
            2'b10:   bm = 8'h0F;
            default: bm = 8'hFF;
        endcase
        return MASK_W'(bm) << off;
    endfunction

    // shift the addressed lanes down, keep size bytes, then sign/zero extend
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [2:0]        f3);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] msk;
        logic              sgn;
        sh = word >> {off, 3'b000};
        case (f3[1:0])
            2'b00: begin
                msk = DATA_W'(8'hFF);
                sgn = sh[7];
            end
            2'b01: begin
                msk = DATA_W'(16'hFFFF);
                sgn = sh[15];
            end
            2'b10: begin
                msk = DATA_W'(32'hFFFF_FFFF);
                sgn = sh[31];
            end
            default: begin
                msk = {DATA_W{1'b1}};
                sgn = sh[DATA_W-1];
            end
        endcase
        sgn = sgn & ~f3[2];
        return (sh & msk) | ({DATA_W{sgn}} & ~msk);
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_req_ready;
    logic              r_wen;
    logic [2:0]        r_funct3;
    logic [OFF_W-1:0]  r_off;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_wen;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [MASK_W-1:0] r_mem_wmask;

    logic [OFF_W-1:0]  w_off;
    logic              w_err;

    assign w_off = req_addr[OFF_W-1:0];
    assign w_err = ~op_legal(req_wen, req_funct3) | misaligned(req_funct3[1:0], w_off);

    // next-state selection for the single-outstanding request FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state, request latch, bus drive and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_req_ready     <= 1'b1;
            r_wen           <= 1'b0;
            r_funct3        <= 3'b000;
            r_off           <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_err      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_wen       <= req_wen;
                        r_funct3    <= req_funct3;
                        r_off       <= w_off;
                        if (w_err) begin
                            // error completes next cycle; bus registers untouched
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_mem_wen       <= req_wen;
                            if (req_wen) begin
                                r_mem_wdata <= req_wdata << {w_off, 3'b000};
                                r_mem_wmask <= store_mask(req_funct3[1:0], w_off);
                            end else begin
                                r_mem_wdata <= '0;
                                r_mem_wmask <= '0;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        if (r_wen) begin
                            r_resp_rdata <= '0;
                        end else begin
                            r_resp_rdata <= load_ext(mem_rdata, r_off, r_funct3);
                        end
                    end
                end
                S_DONE: begin
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_err      = r_resp_err;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Bench for ysyx_24100005_lsu: one 32-bit and one 64-bit instance share the
// stimulus. A byte-level reference model predicts every request's bus beat,
// its response value and the cycle numbers at which they appear.
module tb_ysyx_24100005_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [63:0] req_wdata = 64'd0, mem_rdata = 64'd0;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;

    logic        rr32, rv32, re32, mv32, mw32;
    logic [31:0] rd32, ma32, md32;
    logic [3:0]  mk32;
    logic        rr64, rv64, re64, mv64, mw64;
    logic [63:0] rd64, md64;
    logic [31:0] ma64;
    logic [7:0]  mk64;

    ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(32)) u32 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel64), .req_ready(rr32),
        .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(rv32), .resp_rdata(rd32), .resp_err(re32),
        .mem_req_valid(mv32), .mem_req_ready(mem_req_ready), .mem_addr(ma32), .mem_wen(mw32),
        .mem_wdata(md32), .mem_wmask(mk32), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata[31:0]));

    ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(64)) u64 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel64), .req_ready(rr64),
        .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv64), .resp_rdata(rd64), .resp_err(re64),
        .mem_req_valid(mv64), .mem_req_ready(mem_req_ready), .mem_addr(ma64), .mem_wen(mw64),
        .mem_wdata(md64), .mem_wmask(mk64), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata));

    // outputs of the selected instance, zero-extended to 64 bits
    logic        o_ready, o_rv, o_err, o_mv, o_mwen;
    logic [63:0] o_rdata, o_mwdata;
    logic [31:0] o_maddr;
    logic [7:0]  o_mwmask;
    assign o_ready  = sel64 ? rr64 : rr32;
    assign o_rv     = sel64 ? rv64 : rv32;
    assign o_err    = sel64 ? re64 : re32;
    assign o_mv     = sel64 ? mv64 : mv32;
    assign o_mwen   = sel64 ? mw64 : mw32;
    assign o_rdata  = sel64 ? rd64 : {32'd0, rd32};
    assign o_mwdata = sel64 ? md64 : {32'd0, md32};
    assign o_maddr  = sel64 ? ma64 : ma32;
    assign o_mwmask = sel64 ? mk64 : {4'd0, mk32};

    int tests = 0, failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference model: byte-level rules for legality, lanes and extension
    task automatic model(input bit s64, input bit wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         output bit err, output logic [31:0] maddr, output logic [63:0] mwd,
                         output logic [7:0] mwm, output logic [63:0] rdv);
        int  nb, sz, off;
        bit  legal;
        nb  = s64 ? 8 : 4;
        sz  = 1 << f3[1:0];
        off = int'(addr[2:0]) % nb;
        if (wen) legal = (f3 <= 3'd2) || (s64 && f3 == 3'd3);
        else     legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) ||
                         (s64 && (f3 == 3'd3 || f3 == 3'd6));
        err   = !legal || (off % sz != 0);
        maddr = addr - 32'(off);
        mwd = 64'd0; mwm = 8'd0; rdv = 64'd0;
        if (!err && wen) begin
            mwd = wd << (8 * off);
            if (!s64) mwd[63:32] = 32'd0;
            for (int i = 0; i < sz; i++) mwm[off + i] = 1'b1;
        end
        if (!err && !wen) begin
            for (int i = 0; i < sz; i++) rdv[8*i +: 8] = rd[8*(off+i) +: 8];
            if (!f3[2] && rdv[8*sz-1])
                for (int i = sz; i < nb; i++) rdv[8*i +: 8] = 8'hFF;
        end
    endtask

    // expected timeline of the transaction in flight
    bit          chk_en = 1'b0;
    int          t_acc = -10, t_lo = 0, t_hi = -1, t_done = -10;
    bit          e_err, e_wen;
    logic [31:0] e_maddr;
    logic [63:0] e_mwd, e_rdv;
    logic [7:0]  e_mwm;
    logic [63:0] hold_rd[2];
    bit          hold_err[2];
    int          last_resp_cyc = 0;
    logic [63:0] last_rdata = 64'd0, last_mwdata = 64'd0;
    logic [31:0] last_maddr = 32'd0;
    logic [7:0]  last_mwmask = 8'd0;
    bit          last_err = 1'b0, last_mwen = 1'b0;

    // compare process: every cycle, checked #1 after the active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                bit busy, issue, at_done;
                busy    = (cyc > t_acc) && (cyc <= t_done);
                issue   = (cyc >= t_lo) && (cyc <= t_hi);
                at_done = (cyc >= t_done);
                chk("req_ready", 64'(o_ready), 64'(!busy));
                chk("resp_valid", 64'(o_rv), 64'(cyc == t_done));
                chk("mem_req_valid", 64'(o_mv), 64'(issue));
                if (issue) begin
                    chk("mem_addr", 64'(o_maddr), 64'(e_maddr));
                    chk("mem_wen", 64'(o_mwen), 64'(e_wen));
                    chk("mem_wdata", o_mwdata, e_mwd);
                    chk("mem_wmask", 64'(o_mwmask), 64'(e_mwm));
                end
                chk("resp_rdata", o_rdata, at_done ? e_rdv : hold_rd[sel64]);
                chk("resp_err", 64'(o_err), 64'(at_done ? e_err : hold_err[sel64]));
                if (o_rv) begin
                    last_resp_cyc = cyc; last_rdata = o_rdata; last_err = o_err;
                end
                if (o_mv) begin
                    last_maddr = o_maddr; last_mwdata = o_mwdata;
                    last_mwmask = o_mwmask; last_mwen = o_mwen;
                end
            end
        end
    end

    // one request: slave accepts after rdy idle cycles, responds rsp cycles into WAIT
    task automatic do_txn(input bit s64, input bit wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                          input int rdy, input int rsp);
        bit          err;
        logic [31:0] ma;
        logic [63:0] mwd, rdv;
        logic [7:0]  mwm;
        int          a;
        model(s64, wen, f3, addr, s64 ? wd : {32'd0, wd[31:0]}, s64 ? rd : {32'd0, rd[31:0]},
              err, ma, mwd, mwm, rdv);
        @(negedge clk);
        a = cyc;
        sel64 = s64;
        e_err = err; e_wen = wen; e_maddr = ma; e_mwd = mwd; e_mwm = mwm;
        e_rdv = err ? 64'd0 : rdv;
        t_acc = a;
        t_lo  = err ? 0 : a + 1;
        t_hi  = err ? -1 : a + 1 + rdy;
        t_done = err ? a + 1 : a + 3 + rdy + rsp;
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        while (cyc <= t_done) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_wen = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = {$urandom, $urandom};
            mem_req_ready  = !err && (cyc == a + 1 + rdy);
            mem_resp_valid = !err && (cyc == a + 2 + rdy + rsp);
            mem_rdata      = mem_resp_valid ? rd : {$urandom, $urandom};
        end
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        hold_rd[s64]  = e_rdv;
        hold_err[s64] = e_err;
    endtask

    // reset while the 64-bit instance waits for its response
    task automatic do_abort();
        chk_en = 1'b0;
        @(negedge clk);
        sel64 = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b011; req_addr = 32'h8000_0008;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("abort_busy", 64'(o_ready), 64'd0);
        chk("abort_wait", 64'(o_mv), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_mreq", 64'(o_mv), 64'd0);
        chk("rst_resp_valid", 64'(o_rv), 64'd0);
        chk("rst_rdata", o_rdata, 64'd0);
        chk("rst_wmask", 64'(o_mwmask), 64'd0);
        chk("rst_maddr", 64'(o_maddr), 64'd0);
        @(negedge clk);
        rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("late_resp_ignored", 64'(o_rv), 64'd0);
            chk("late_resp_ready", 64'(o_ready), 64'd1);
        end
        hold_rd[0] = 64'd0; hold_rd[1] = 64'd0; hold_err[0] = 1'b0; hold_err[1] = 1'b0;
        t_acc = -10; t_lo = 0; t_hi = -1; t_done = -10;
        e_rdv = 64'd0; e_err = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        hold_rd[0] = 64'd0; hold_rd[1] = 64'd0; hold_err[0] = 1'b0; hold_err[1] = 1'b0;
        e_rdv = 64'd0; e_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_ready32", 64'(rr32), 64'd1);
        chk("reset_ready64", 64'(rr64), 64'd1);
        chk("reset_mreq", 64'({mv32, mv64, rv32, rv64, mw32, mw64}), 64'd0);
        chk("reset_bus64", md64 | 64'(mk64) | 64'(ma64) | rd64, 64'd0);
        chk("reset_bus32", 64'(md32) | 64'(mk32) | 64'(ma32) | 64'(rd32), 64'd0);
        chk_en = 1'b1;

        do_txn(1'b0, 1'b0, 3'b000, 32'h8000_0003, 64'd0, 64'h0000_0000_80FF_1234, 0, 0);
        chk("lb_latency", 64'(last_resp_cyc - t_acc), 64'd3);
        chk("lb_rdata", last_rdata, 64'h0000_0000_FFFF_FF80);
        chk("lb_maddr", 64'(last_maddr), 64'h8000_0000);
        do_txn(1'b0, 1'b0, 3'b101, 32'h8000_0002, 64'd0, 64'h0000_0000_9ABC_5678, 0, 0);
        chk("lhu_rdata", last_rdata, 64'h0000_0000_0000_9ABC);
        do_txn(1'b0, 1'b0, 3'b001, 32'h8000_0002, 64'd0, 64'h0000_0000_9ABC_5678, 1, 2);
        chk("lh_rdata", last_rdata, 64'h0000_0000_FFFF_9ABC);
        do_txn(1'b0, 1'b1, 3'b000, 32'h8000_0001, 64'h0000_0000_1122_33AA, 64'd0, 0, 0);
        chk("sb_wdata", last_mwdata, 64'h0000_0000_2233_AA00);
        chk("sb_wmask", 64'(last_mwmask), 64'h2);
        chk("sb_wen", 64'(last_mwen), 64'd1);
        chk("sb_resp", {last_rdata[62:0], last_err}, 64'd0);
        do_txn(1'b0, 1'b1, 3'b010, 32'h8000_0002, 64'h55, 64'd0, 0, 0);
        chk("sw_mis_latency", 64'(last_resp_cyc - t_acc), 64'd1);
        chk("sw_mis_err", 64'(last_err), 64'd1);
        do_txn(1'b0, 1'b0, 3'b111, 32'h8000_0000, 64'd0, 64'd0, 0, 0);
        chk("f3_111_err", 64'(last_err), 64'd1);
        do_txn(1'b0, 1'b0, 3'b010, 32'h8000_0010, 64'd0, 64'h0000_0000_CAFE_F00D, 5, 4);
        chk("bp_latency", 64'(last_resp_cyc - t_acc), 64'd12);
        chk("bp_rdata", last_rdata, 64'h0000_0000_CAFE_F00D);
        do_txn(1'b1, 1'b1, 3'b011, 32'h8000_0008, 64'h0102_0304_0506_0708, 64'd0, 0, 1);
        chk("sd_wmask", 64'(last_mwmask), 64'hFF);
        do_txn(1'b1, 1'b0, 3'b110, 32'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 2, 0);
        chk("lwu_rdata", last_rdata, 64'h0000_0000_8765_4321);
        do_txn(1'b0, 1'b0, 3'b011, 32'h8000_0000, 64'd0, 64'd0, 0, 0);
        chk("ld_on_32_err", 64'(last_err), 64'd1);
        do_abort();

        for (int n = 0; n < 250; n++) begin
            bit          s64, wen;
            logic [2:0]  f3;
            logic [31:0] addr;
            s64  = 1'($urandom);
            wen  = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            do_txn(s64, wen, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_lsu.md
Name: ysyx_24100005_lsu

Overview:
- Multi-cycle load/store unit that replaces the core's combinational memory access.
- Takes one load/store request from the EXU over a valid/ready handshake and issues an aligned bus transaction to a memory slave with variable latency.
- Performs byte-lane extraction and sign/zero extension for loads, and lane shifting plus write-mask generation for stores.
- Generalises the fixed 32-bit path to DATA_W of 32 or 64, adds misalignment/illegal-op error reporting, and supports back-pressure on both request and response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus data width; legal values are 32 or 64.
- MASK_W, DATA_W/8, byte write-mask width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  EXU request valid.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address (rs1 + imm).
- req_wdata  in  DATA_W  store data (rs2), LSB-aligned.
- resp_valid  out  1  result/completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address or illegal funct3.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_addr  out  ADDR_W  req_addr with the low log2(MASK_W) bits cleared.
- mem_wen  out  1  bus write.
- mem_wdata  out  DATA_W  store data shifted into its byte lanes.
- mem_wmask  out  MASK_W  byte enables.
- mem_resp_valid  in  1  read data valid / write acknowledge.
- mem_rdata  in  DATA_W  full aligned bus word.

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_req_valid=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0. req_ready=1 from the first cycle after reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - req_ready=1.
  - On req_valid: latch wen/funct3/addr/wdata; compute size, offset and error.
  - If error: go to DONE with resp_err=1.
  - Otherwise: go to ISSUE.
- ISSUE
  - mem_req_valid=1; mem_addr/mem_wen/mem_wdata/mem_wmask held stable.
  - Stays in ISSUE until mem_req_ready=1, then goes to WAIT.
- WAIT
  - mem_req_valid=0.
  - On mem_resp_valid: for loads, register the extended data into resp_rdata; go to DONE.
  - mem_resp_valid is sampled only in WAIT; a response in the same cycle as acceptance is not allowed.
- DONE
  - resp_valid=1 for exactly one cycle; then back to IDLE.
  - resp_rdata and resp_err hold their value until the next DONE.
- Latency: the minimum is 3 cycles from the request accept to resp_valid (zero-wait slave). An error response is 1 cycle after accept.
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Loads, DATA_W=64 only: 011 ld, 110 lwu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Stores, DATA_W=64 only: 011 sd.
  - Every other funct3 → resp_err=1.
- Access size is 1/2/4/8 bytes from funct3[1:0].
  - off = addr[log2(MASK_W)-1:0].
  - Misaligned when off is not a multiple of the size.
  - Errors never drive the bus.
- Load extraction: shift mem_rdata right by off*8, keep size*8 bits, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to DATA_W.
- Store lanes:
  - mem_wdata = req_wdata << off*8.
  - mem_wmask = ((1<<size)-1) << off.
  - Loads drive mem_wmask=0 and mem_wdata=0.
- No back-to-back pipelining: at most one outstanding transaction.
- Reset mid-operation: returns to IDLE on the next edge, mem_req_valid drops, no resp_valid. A late mem_resp_valid arriving in IDLE is ignored.

Test Plan:
- DATA_W=32, lb at addr 0x8000_0003, mem_rdata=0x80FF_1234, zero-wait slave → mem_addr=0x8000_0000; resp_rdata=0xFFFF_FF80; resp_valid exactly 3 cycles after accept.
- lhu at 0x8000_0002, mem_rdata=0x9ABC_5678 → resp_rdata=0x0000_9ABC. lh at the same address → 0xFFFF_9ABC.
- sb at 0x8000_0001, wdata=0x1122_33AA → mem_wen=1, mem_wdata=0x2233_AA00, mem_wmask=4'b0010. resp_rdata=0, resp_err=0.
- sw at 0x8000_0002 → resp_err=1, resp_valid 1 cycle after accept, mem_req_valid never asserted. funct3=111 load → same response.
- mem_req_ready held low 5 cycles, then mem_resp_valid delayed 4 cycles → bus signals stable throughout ISSUE, single resp_valid pulse, req_ready=0 until back in IDLE.
- DATA_W=64:
  - sd at 0x...08 → mem_wmask=8'hFF.
  - lwu at 0x...04 with mem_rdata=0x8765_4321_0000_0000 → resp_rdata=0x0000_0000_8765_4321.
  - rst asserted in WAIT → IDLE next cycle; a subsequent mem_resp_valid produces no resp_valid.
